// File: rtl/result_collector_if.sv
// Bundle of the mode, unit-result and writeback handshake signals around result_collector.
// The collector connects through the slave modport; the launching/consuming side uses master.
interface result_collector_if #(
  parameter int DATA_W = 4
) ();
  logic                  start;
  logic                  from_mul;
  logic                  from_div;
  logic                  from_sqr;
  logic                  alu_valid;
  logic [DATA_W:0]       alu_result;
  logic                  mul_valid;
  logic [2*DATA_W-1:0]   mul_result;
  logic                  div_valid;
  logic [DATA_W-1:0]     div_quot;
  logic [DATA_W-1:0]     div_rem;
  logic                  div_dbz;
  logic                  sqr_valid;
  logic [DATA_W-1:0]     sqr_root;
  logic [DATA_W-1:0]     sqr_rem;
  logic                  res_ready;
  logic                  res_valid;
  logic [2*DATA_W-1:0]   result;
  logic [DATA_W-1:0]     aux;
  logic [1:0]            src;
  logic                  err_dbz;
  logic                  err_mode;
  logic                  err_timeout;
  logic                  busy;

  modport slave (
    input  start, from_mul, from_div, from_sqr,
    input  alu_valid, alu_result, mul_valid, mul_result,
    input  div_valid, div_quot, div_rem, div_dbz,
    input  sqr_valid, sqr_root, sqr_rem, res_ready,
    output res_valid, result, aux, src, err_dbz, err_mode, err_timeout, busy
  );

  modport master (
    output start, from_mul, from_div, from_sqr,
    output alu_valid, alu_result, mul_valid, mul_result,
    output div_valid, div_quot, div_rem, div_dbz,
    output sqr_valid, sqr_root, sqr_rem, res_ready,
    input  res_valid, result, aux, src, err_dbz, err_mode, err_timeout, busy
  );
endinterface

// File: rtl/result_collector.sv
// Collects the result of the unit selected by the mode bits, normalises it and offers it downstream.
// Optional WAIT-state timeout is built when RESULT_TIMEOUT_EN is defined.
module result_collector #(
  parameter int DATA_W         = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic               clk,
  input  logic               rst,
  result_collector_if.slave  bus,
  output logic [1:0]         o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_res_valid;
  logic [2*DATA_W-1:0] r_result;
  logic [DATA_W-1:0]   r_aux;
  logic [1:0]          r_src;
  logic                r_err_dbz;
  logic                r_err_mode;
  logic                r_busy;

  logic                w_mode_bad;
  logic [1:0]          w_mode_src;
  logic                w_unit_valid;
  logic [2*DATA_W-1:0] w_norm_result;
  logic [DATA_W-1:0]   w_norm_aux;
  logic                w_norm_dbz;

  assign w_mode_bad = (bus.from_mul & bus.from_div) | (bus.from_mul & bus.from_sqr) |
                      (bus.from_div & bus.from_sqr);
  assign w_mode_src = bus.from_mul ? 2'd1 : bus.from_div ? 2'd2 : bus.from_sqr ? 2'd3 : 2'd0;

  // Only the unit latched at start may complete the operation; other valids are stray.
  always_comb begin
    w_unit_valid  = 1'b0;
    w_norm_result = '0;
    w_norm_aux    = '0;
    w_norm_dbz    = 1'b0;
    case (r_src)
      2'd0: begin
        w_unit_valid  = bus.alu_valid;
        w_norm_result = (2*DATA_W)'(bus.alu_result);
      end
      2'd1: begin
        w_unit_valid  = bus.mul_valid;
        w_norm_result = bus.mul_result;
      end
      2'd2: begin
        w_unit_valid = bus.div_valid;
        w_norm_dbz   = bus.div_dbz;
        if (!bus.div_dbz) begin
          w_norm_result = (2*DATA_W)'(bus.div_quot);
          w_norm_aux    = bus.div_rem;
        end
      end
      default: begin
        w_unit_valid  = bus.sqr_valid;
        w_norm_result = (2*DATA_W)'(bus.sqr_root);
        w_norm_aux    = bus.sqr_rem;
      end
    endcase
  end

`ifdef RESULT_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_timeout;
  logic             w_timeout;
  assign w_timeout       = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.err_timeout = r_err_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg    = ^{TIMEOUT_CYCLES, CNT_W};
  assign bus.err_timeout = 1'b0;
`endif

  // Handshake: res_valid is held with stable result/aux/src/err_* until the cycle in which
  // res_ready is also high; that cycle transfers the result and res_valid drops the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_res_valid <= 1'b0;
      r_result    <= '0;
      r_aux       <= '0;
      r_src       <= 2'd0;
      r_err_dbz   <= 1'b0;
      r_err_mode  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef RESULT_TIMEOUT_EN
      r_cnt         <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (w_mode_bad) begin
              r_state     <= S_HOLD;
              r_res_valid <= 1'b1;
              r_err_mode  <= 1'b1;
              r_result    <= '0;
              r_aux       <= '0;
              r_src       <= 2'd0;
            end else begin
              r_state <= S_WAIT;
              r_src   <= w_mode_src;
`ifdef RESULT_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (w_unit_valid) begin
            r_state     <= S_HOLD;
            r_res_valid <= 1'b1;
            r_result    <= w_norm_result;
            r_aux       <= w_norm_aux;
            r_err_dbz   <= w_norm_dbz;
          end
`ifdef RESULT_TIMEOUT_EN
          else if (w_timeout) begin
            r_state       <= S_HOLD;
            r_res_valid   <= 1'b1;
            r_err_timeout <= 1'b1;
            r_result      <= '0;
            r_aux         <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_HOLD: begin
          if (r_res_valid && bus.res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_err_dbz   <= 1'b0;
            r_err_mode  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef RESULT_TIMEOUT_EN
            r_err_timeout <= 1'b0;
`endif
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.result    = r_result;
  assign bus.aux       = r_aux;
  assign bus.src       = r_src;
  assign bus.err_dbz   = r_err_dbz;
  assign bus.err_mode  = r_err_mode;
  assign bus.busy      = r_busy;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed vector table, randomized transactions against a
// rule-level model, plus hand sequences for reset, start-in-HOLD and the WAIT timeout.
module tb_result_collector;
  localparam int DW      = 4;
  localparam int W       = 17;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  result_collector_if #(.DATA_W(DW)) bus ();

  result_collector #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // exp packs {result[7:0], aux[3:0], src[1:0], err_dbz, err_mode, err_timeout}
  typedef struct {
    logic [2:0] mode;
    logic [4:0] alu;
    logic [7:0] mul;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic [3:0] root;
    logic [3:0] srem;
    int         vdelay;
    int         rdelay;
    int         stray_u;
    bit         same;
    logic [W-1:0] exp;
  } vec_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  vec_t         vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] obs();
    return {bus.result, bus.aux, bus.src, bus.err_dbz, bus.err_mode, bus.err_timeout};
  endfunction

  function automatic int unit_of(input logic [2:0] m);
    if (m == 3'b100) return 1;
    if (m == 3'b010) return 2;
    if (m == 3'b001) return 3;
    return 0;
  endfunction

  // Rule-level reference: what the consumer should see for one launched operation.
  function automatic logic [W-1:0] model(input vec_t v);
    logic [7:0] res;
    logic [3:0] aux;
    logic       dbz;
    if ($countones(v.mode) >= 2) return {8'h00, 4'h0, 2'd0, 3'b010};
    res = 8'h00;
    aux = 4'h0;
    dbz = 1'b0;
    case (unit_of(v.mode))
      0: res = 8'(v.alu);
      1: res = v.mul;
      2: begin
        dbz = v.dbz;
        if (!v.dbz) begin
          res = 8'(v.q);
          aux = v.r;
        end
      end
      default: begin
        res = 8'(v.root);
        aux = v.srem;
      end
    endcase
    return {res, aux, 2'(unit_of(v.mode)), dbz, 2'b00};
  endfunction

  task automatic set_bus(input vec_t v, input bit inv);
    bus.alu_result = inv ? ~v.alu  : v.alu;
    bus.mul_result = inv ? ~v.mul  : v.mul;
    bus.div_quot   = inv ? ~v.q    : v.q;
    bus.div_rem    = inv ? ~v.r    : v.r;
    bus.div_dbz    = inv ? ~v.dbz  : v.dbz;
    bus.sqr_root   = inv ? ~v.root : v.root;
    bus.sqr_rem    = inv ? ~v.srem : v.srem;
  endtask

  task automatic set_valid(input int u, input logic val);
    case (u)
      0: bus.alu_valid = val;
      1: bus.mul_valid = val;
      2: bus.div_valid = val;
      default: bus.sqr_valid = val;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int u;
    int waited;
    bit illegal;
    u       = unit_of(v.mode);
    illegal = ($countones(v.mode) >= 2);
    exp_q.push_back(v.exp);
    {bus.from_mul, bus.from_div, bus.from_sqr} = v.mode;
    bus.start = 1'b1;
    set_bus(v, 1'b1);
    if (v.same) set_valid(u, 1'b1);
    tick();
    bus.start = 1'b0;
    set_valid(u, 1'b0);
    {bus.from_mul, bus.from_div, bus.from_sqr} = 3'($urandom_range(0, 7));
    set_bus(v, 1'b0);
    if (!illegal) begin
      check({tag, "_wait_entry"}, {bus.busy, bus.res_valid}, 2'b10);
      for (int i = 0; i < v.vdelay; i++) begin
        if (i == 0 && v.stray_u >= 0) begin
          set_bus(v, 1'b1);
          set_valid(v.stray_u, 1'b1);
        end
        tick();
        if (v.stray_u >= 0) set_valid(v.stray_u, 1'b0);
        set_bus(v, 1'b0);
      end
      set_valid(u, 1'b1);
      tick();
      set_valid(u, 1'b0);
      set_bus(v, 1'b1);
    end
    check({tag, "_latency"}, bus.res_valid, 1'b1);
    waited = 0;
    while (!bus.res_valid && waited < 20) begin
      tick();
      waited++;
    end
    for (int i = 0; i < v.rdelay; i++) begin
      check({tag, "_hold"}, {bus.res_valid, obs()}, {1'b1, v.exp});
      tick();
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    if (bus.res_valid) check({tag, "_handshake"}, obs(), exp_q.pop_front());
    else check({tag, "_handshake_valid"}, bus.res_valid, 1'b1);
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_clear"}, {bus.res_valid, bus.busy, bus.err_dbz, bus.err_mode, bus.err_timeout},
          5'b0);
    check({tag, "_keep"}, {bus.result, bus.aux}, v.exp[W-1:5]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic vec_t mk(input logic [2:0] m, input logic [4:0] a, input logic [7:0] p,
                              input logic [3:0] q, input logic [3:0] r, input logic z,
                              input logic [3:0] rt, input logic [3:0] sr, input int vd,
                              input int rd, input int su, input bit sm, input logic [W-1:0] e);
    vec_t v;
    v.mode = m; v.alu = a; v.mul = p; v.q = q; v.r = r; v.dbz = z;
    v.root = rt; v.srem = sr; v.vdelay = vd; v.rdelay = rd; v.stray_u = su; v.same = sm;
    v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   cycles;
    logic [2:0] legal[4];
    logic [2:0] bad[4];
    legal = '{3'b000, 3'b100, 3'b010, 3'b001};
    bad   = '{3'b110, 3'b101, 3'b011, 3'b111};

    rst = 1'b1;
    bus.start = 1'b0; bus.res_ready = 1'b0;
    {bus.from_mul, bus.from_div, bus.from_sqr} = 3'b000;
    bus.alu_valid = 1'b0; bus.mul_valid = 1'b0; bus.div_valid = 1'b0; bus.sqr_valid = 1'b0;
    bus.alu_result = '0; bus.mul_result = '0; bus.div_quot = '0; bus.div_rem = '0;
    bus.div_dbz = 1'b0; bus.sqr_root = '0; bus.sqr_rem = '0;

    vecs[0] = mk(3'b100, 5'h00, 8'h2A, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2, 0, -1, 1'b0, {8'h2A, 4'h0, 2'd1, 3'b000});
    vecs[1] = mk(3'b010, 5'h00, 8'h00, 4'd3, 4'd1, 1'b0, 4'h0, 4'h0, 1, 5, -1, 1'b0, {8'h03, 4'h1, 2'd2, 3'b000});
    vecs[2] = mk(3'b010, 5'h00, 8'h00, 4'd9, 4'd7, 1'b1, 4'h0, 4'h0, 0, 1, -1, 1'b0, {8'h00, 4'h0, 2'd2, 3'b100});
    vecs[3] = mk(3'b110, 5'h00, 8'h55, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 0, 2, -1, 1'b0, {8'h00, 4'h0, 2'd0, 3'b010});
    vecs[4] = mk(3'b000, 5'h13, 8'h00, 4'h0, 4'h0, 1'b0, 4'h9, 4'h2, 2, 0, 3, 1'b0, {8'h13, 4'h0, 2'd0, 3'b000});
    vecs[5] = mk(3'b001, 5'h00, 8'h00, 4'h0, 4'h0, 1'b0, 4'd5, 4'd3, 1, 2, -1, 1'b1, {8'h05, 4'h3, 2'd3, 3'b000});
    vecs[6] = mk(3'b000, 5'h1F, 8'h00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 0, 0, -1, 1'b1, {8'h1F, 4'h0, 2'd0, 3'b000});
    vecs[7] = mk(3'b111, 5'h00, 8'h00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 0, 0, -1, 1'b0, {8'h00, 4'h0, 2'd0, 3'b010});
    vecs[8] = mk(3'b101, 5'h00, 8'h00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 0, 3, -1, 1'b0, {8'h00, 4'h0, 2'd0, 3'b010});
    vecs[9] = mk(3'b100, 5'h00, 8'hFF, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 3, 1, 2, 1'b0, {8'hFF, 4'h0, 2'd1, 3'b000});

    tick();
    tick();
    check("reset_outputs", {bus.res_valid, obs(), bus.busy, dbg_state}, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      v.mode    = ($urandom_range(0, 4) == 0) ? bad[$urandom_range(0, 3)] : legal[$urandom_range(0, 3)];
      v.alu     = 5'($urandom);
      v.mul     = 8'($urandom);
      v.q       = 4'($urandom);
      v.r       = 4'($urandom);
      v.dbz     = ($urandom_range(0, 3) == 0);
      v.root    = 4'($urandom);
      v.srem    = 4'($urandom);
      v.vdelay  = $urandom_range(0, 4);
      v.rdelay  = $urandom_range(0, 3);
      v.stray_u = -1;
      if (v.vdelay > 0 && $urandom_range(0, 1) == 1)
        v.stray_u = (unit_of(v.mode) + $urandom_range(1, 3)) % 4;
      v.same    = $urandom_range(0, 1);
      v.exp     = model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // start while in HOLD must not relaunch
    {bus.from_mul, bus.from_div, bus.from_sqr} = 3'b001;
    bus.start = 1'b1;
    bus.sqr_root = 4'd7; bus.sqr_rem = 4'd2;
    tick();
    bus.start = 1'b0;
    bus.sqr_valid = 1'b1;
    tick();
    bus.sqr_valid = 1'b0;
    {bus.from_mul, bus.from_div, bus.from_sqr} = 3'b100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("hold_start_ignored", {bus.res_valid, obs()}, {1'b1, 8'h07, 4'h2, 2'd3, 3'b000});
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    tick();
    check("hold_start_no_relaunch", {bus.busy, bus.res_valid}, 2'b00);

    // asynchronous reset in WAIT drops the operation
    {bus.from_mul, bus.from_div, bus.from_sqr} = 3'b010;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("pre_reset_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("async_reset", {bus.res_valid, obs(), bus.busy}, '0);
    bus.div_valid = 1'b1;
    bus.div_quot = 4'd5;
    tick();
    bus.div_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("reset_dropped", {bus.res_valid, bus.busy, obs()}, '0);

`ifdef RESULT_TIMEOUT_EN
    bus.alu_result = 5'h0A;
    {bus.from_mul, bus.from_div, bus.from_sqr} = 3'b000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cycles = 0;
    while (!bus.res_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    check("timeout_cycles", cycles, TIMEOUT);
    check("timeout_flags", {bus.res_valid, obs()}, {1'b1, 8'h00, 4'h0, 2'd0, 3'b001});
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("timeout_clear", {bus.res_valid, bus.err_timeout, bus.busy}, 3'b000);
    // a valid in the last WAIT cycle beats the timeout
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    bus.alu_valid = 1'b1;
    tick();
    bus.alu_valid = 1'b0;
    check("timeout_valid_wins", {bus.res_valid, obs()}, {1'b1, 8'h0A, 4'h0, 2'd0, 3'b000});
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
`else
    {bus.from_mul, bus.from_div, bus.from_sqr} = 3'b000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 110; i++) tick();
    check("no_timeout_busy", {bus.busy, bus.res_valid, bus.err_timeout}, 3'b100);
    do_reset();
`endif
    check("final_idle", {bus.busy, bus.res_valid}, 2'b00);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
